// File: rtl/window_scan_fsm_if.sv
// Signal bundle between the raster-scan controller, its column counter and the
// classifier scheduler. The slave side is the controller, the master side drives it.
interface window_scan_fsm_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    start;
    logic                    abort;
    logic                    pixel_valid;
    logic [DATA_WIDTH-1:0]   max_row;
    logic [DATA_WIDTH-1:0]   col_ctr;
    logic                    col_end;
    logic                    col_enable;
    logic                    col_reset;
    logic                    busy;
    logic [DATA_WIDTH-1:0]   row_ctr;
    logic                    window_valid;
    logic [DATA_WIDTH-1:0]   win_x;
    logic [DATA_WIDTH-1:0]   win_y;
    logic [2*DATA_WIDTH-1:0] window_count;
    logic                    frame_start;
    logic                    frame_done;

    modport master (
        output start, abort, pixel_valid, max_row, col_ctr, col_end,
        input  col_enable, col_reset, busy, row_ctr, window_valid,
               win_x, win_y, window_count, frame_start, frame_done
    );

    modport slave (
        input  start, abort, pixel_valid, max_row, col_ctr, col_end,
        output col_enable, col_reset, busy, row_ctr, window_valid,
               win_x, win_y, window_count, frame_start, frame_done
    );
endinterface

// File: rtl/window_scan_fsm.sv
// Raster-scan controller: gates the column counter, tracks rows and flags every
// pixel where a complete WINDOW_SIZE x WINDOW_SIZE Haar window ends.
module window_scan_fsm #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_SIZE = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    window_scan_fsm_if.slave bus
);
    localparam int CW = 2 * DATA_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DATA_WIDTH-1:0] WIN_LAST  = DATA_WIDTH'(WINDOW_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] ROW_ONE   = DATA_WIDTH'(1);
    localparam logic [CW-1:0]         COUNT_ONE = CW'(1);

    logic [1:0]            state_q,      state_d;
    logic [DATA_WIDTH-1:0] maxRow_q,     maxRow_d;
    logic [DATA_WIDTH-1:0] rowCtr_q,     rowCtr_d;
    logic                  winValid_q,   winValid_d;
    logic [DATA_WIDTH-1:0] winX_q,       winX_d;
    logic [DATA_WIDTH-1:0] winY_q,       winY_d;
    logic [CW-1:0]         winCount_q,   winCount_d;
    logic                  frameStart_q, frameStart_d;
    logic                  frameDone_q,  frameDone_d;
    logic                  colReset_q,   colReset_d;

    logic accept;
    logic colOk;
    logic rowOk;
    logic winHit;

    // A one-pixel window is complete everywhere, so the threshold compare is dropped.
    if (WINDOW_SIZE > 1) begin : g_thresh
        assign colOk = (bus.col_ctr >= WIN_LAST);
        assign rowOk = (rowCtr_q >= WIN_LAST);
    end else begin : g_any
        assign colOk = 1'b1;
        assign rowOk = 1'b1;
    end

    assign accept = (state_q == SCAN) && !colReset_q && bus.pixel_valid;
    assign winHit = accept && colOk && rowOk;

    always_comb begin
        state_d      = state_q;
        maxRow_d     = maxRow_q;
        rowCtr_d     = rowCtr_q;
        winValid_d   = 1'b0;
        winX_d       = winX_q;
        winY_d       = winY_q;
        winCount_d   = winCount_q;
        frameStart_d = 1'b0;
        frameDone_d  = 1'b0;
        colReset_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d      = SCAN;
                    frameStart_d = 1'b1;
                    colReset_d   = 1'b1;
                    maxRow_d     = bus.max_row;
                    rowCtr_d     = '0;
                    winCount_d   = '0;
                end
            end
            SCAN: begin
                // Abort takes priority over a pixel arriving in the same cycle.
                if (bus.abort) begin
                    state_d    = IDLE;
                    colReset_d = 1'b1;
                    rowCtr_d   = '0;
                end else if (accept) begin
                    if (winHit) begin
                        winValid_d = 1'b1;
                        winX_d     = bus.col_ctr - WIN_LAST;
                        winY_d     = rowCtr_q - WIN_LAST;
                        if (winCount_q != '1) begin
                            winCount_d = winCount_q + COUNT_ONE;
                        end
                    end
                    if (bus.col_end) begin
                        if (rowCtr_q == maxRow_q) begin
                            state_d     = DONE;
                            frameDone_d = 1'b1;
                        end else begin
                            rowCtr_d = rowCtr_q + ROW_ONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.abort) begin
                    colReset_d = 1'b1;
                    rowCtr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            maxRow_q     <= '0;
            rowCtr_q     <= '0;
            winValid_q   <= 1'b0;
            winX_q       <= '0;
            winY_q       <= '0;
            winCount_q   <= '0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
            colReset_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            maxRow_q     <= maxRow_d;
            rowCtr_q     <= rowCtr_d;
            winValid_q   <= winValid_d;
            winX_q       <= winX_d;
            winY_q       <= winY_d;
            winCount_q   <= winCount_d;
            frameStart_q <= frameStart_d;
            frameDone_q  <= frameDone_d;
            colReset_q   <= colReset_d;
        end
    end

    // The column counter is held clear for as long as this block is in reset.
    assign bus.col_reset    = colReset_q || !rst_n;
    assign bus.col_enable   = accept;
    assign bus.busy         = (state_q == SCAN);
    assign bus.row_ctr      = rowCtr_q;
    assign bus.window_valid = winValid_q;
    assign bus.win_x        = winX_q;
    assign bus.win_y        = winY_q;
    assign bus.window_count = winCount_q;
    assign bus.frame_start  = frameStart_q;
    assign bus.frame_done   = frameDone_q;

endmodule

// File: tb/tb_window_scan_fsm.sv
// Bench for window_scan_fsm: a 4-column raster with WINDOW_SIZE=3 checked against a
// pixel-index model, plus a WINDOW_SIZE=1 instance driven into count saturation.
`timescale 1ns/1ps
module tb_window_scan_fsm;
    localparam int DW    = 4;
    localparam int WS    = 3;
    localparam int COLS  = 4;
    localparam int COLS1 = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    window_scan_fsm_if #(.DATA_WIDTH(DW)) bus0 ();
    window_scan_fsm_if #(.DATA_WIDTH(DW)) bus1 ();

    window_scan_fsm #(.DATA_WIDTH(DW), .WINDOW_SIZE(WS)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    window_scan_fsm #(.DATA_WIDTH(DW), .WINDOW_SIZE(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Column counters standing in for the real ones, wrapping on their last column.
    always @(posedge clk) begin
        if (bus0.col_reset)       bus0.col_ctr <= '0;
        else if (bus0.col_enable) bus0.col_ctr <= bus0.col_end ? 4'(0) : bus0.col_ctr + 4'(1);
        if (bus1.col_reset)       bus1.col_ctr <= '0;
        else if (bus1.col_enable) bus1.col_ctr <= bus1.col_end ? 4'(0) : bus1.col_ctr + 4'(1);
    end
    assign bus0.col_end = (bus0.col_ctr == 4'(COLS - 1));
    assign bus1.col_end = (bus1.col_ctr == 4'(COLS1 - 1));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One frame on dut0. validPct<0 toggles pixel_valid 1/0; abortAfter>=0 aborts once
    // that many pixels have been accepted.
    task automatic applyStimulus(input int maxRow, input int validPct, input int abortAfter);
        int total, n, hits, lastIdx, col, row, expRow;
        bit lastAcc, finished, pv, expHit;
        total    = COLS * (maxRow + 1);
        n        = 0;
        hits     = 0;
        lastIdx  = 0;
        lastAcc  = 1'b0;
        finished = 1'b0;

        @(negedge clk);
        bus0.start       = 1'b1;
        bus0.abort       = 1'b0;
        bus0.max_row     = DW'(maxRow);
        bus0.pixel_valid = 1'b1;
        #1 checkOutput("idle_col_enable", bus0.col_enable, 0);

        @(negedge clk);
        bus0.start   = 1'b0;
        bus0.max_row = DW'($urandom_range(15));
        checkOutput("frame_start", bus0.frame_start, 1);
        checkOutput("start_col_reset", bus0.col_reset, 1);
        checkOutput("start_busy", bus0.busy, 1);
        checkOutput("start_row_ctr", bus0.row_ctr, 0);
        checkOutput("start_window_count", bus0.window_count, 0);
        bus0.pixel_valid = 1'b1;
        #1 checkOutput("gated_col_enable", bus0.col_enable, 0);

        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            expHit = 1'b0;
            col    = lastIdx % COLS;
            row    = lastIdx / COLS;
            if (lastAcc) expHit = (col >= WS - 1) && (row >= WS - 1);
            checkOutput("window_valid", bus0.window_valid, expHit);
            if (expHit) begin
                hits++;
                checkOutput("win_x", bus0.win_x, col - (WS - 1));
                checkOutput("win_y", bus0.win_y, row - (WS - 1));
            end
            checkOutput("window_count", bus0.window_count, (hits > 255) ? 255 : hits);
            checkOutput("frame_start_low", bus0.frame_start, 0);
            checkOutput("col_reset_low", bus0.col_reset, 0);
            expRow = (n / COLS > maxRow) ? maxRow : n / COLS;
            checkOutput("row_ctr", bus0.row_ctr, expRow);

            if (lastAcc && lastIdx == total - 1) begin
                checkOutput("frame_done", bus0.frame_done, 1);
                checkOutput("done_busy", bus0.busy, 0);
                bus0.pixel_valid = 1'b1;
                #1 checkOutput("done_col_enable", bus0.col_enable, 0);
                @(negedge clk);
                checkOutput("idle_frame_done", bus0.frame_done, 0);
                checkOutput("idle_busy", bus0.busy, 0);
                checkOutput("idle_window_valid", bus0.window_valid, 0);
                checkOutput("idle_row_hold", bus0.row_ctr, maxRow);
                checkOutput("idle_count_hold", bus0.window_count, hits);
                checkOutput("idle_ignores_pixel", bus0.col_enable, 0);
                bus0.pixel_valid = 1'b0;
                finished = 1'b1;
            end else begin
                checkOutput("frame_done_low", bus0.frame_done, 0);
                checkOutput("scan_busy", bus0.busy, 1);
                if (n == abortAfter) begin
                    bus0.pixel_valid = 1'b0;
                    bus0.abort       = 1'b1;
                    #1 checkOutput("abort_col_enable", bus0.col_enable, 0);
                    @(negedge clk);
                    bus0.abort = 1'b0;
                    checkOutput("abort_busy", bus0.busy, 0);
                    checkOutput("abort_col_reset", bus0.col_reset, 1);
                    checkOutput("abort_row_ctr", bus0.row_ctr, 0);
                    checkOutput("abort_frame_done", bus0.frame_done, 0);
                    checkOutput("abort_window_valid", bus0.window_valid, 0);
                    checkOutput("abort_count_hold", bus0.window_count, hits);
                    @(negedge clk);
                    checkOutput("post_abort_col_reset", bus0.col_reset, 0);
                    checkOutput("post_abort_busy", bus0.busy, 0);
                    finished = 1'b1;
                end else begin
                    pv = (validPct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < validPct);
                    bus0.pixel_valid = pv;
                    #1 checkOutput("col_enable", bus0.col_enable, pv);
                    lastAcc = pv;
                    lastIdx = n;
                    if (pv) n++;
                end
            end
        end
        if (!finished) checkOutput("frame_timeout", 0, 1);
    endtask

    initial begin
        int  n1, idx1, total, abortAt;
        bit  acc1, fin1;

        rst_n = 1'b0;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.pixel_valid = 1'b0; bus0.max_row = '0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.pixel_valid = 1'b0; bus1.max_row = '0;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkOutput("rst_col_reset", bus0.col_reset, 1);
        checkOutput("rst_busy", bus0.busy, 0);
        checkOutput("rst_frame_start", bus0.frame_start, 0);
        checkOutput("rst_window_count", bus0.window_count, 0);
        rst_n = 1'b1;
        #1 checkOutput("rel_col_reset", bus0.col_reset, 0);

        $display("[TB] directed frames");
        applyStimulus(3, 100, -1);
        applyStimulus(3, -1, -1);
        applyStimulus(3, 100, 6);
        applyStimulus(3, 100, -1);
        applyStimulus(1, 100, -1);

        $display("[TB] start with abort in idle");
        @(negedge clk);
        bus0.start = 1'b1; bus0.abort = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.abort = 1'b0;
        checkOutput("sa_frame_start", bus0.frame_start, 0);
        checkOutput("sa_busy", bus0.busy, 0);
        checkOutput("sa_col_reset", bus0.col_reset, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 10; f++) begin
            int r;
            r       = $urandom_range(6);
            total   = COLS * (r + 1);
            abortAt = ($urandom_range(3) == 0) ? int'($urandom_range(total - 1)) : -1;
            applyStimulus(r, int'($urandom_range(100, 30)), abortAt);
        end

        $display("[TB] reset during scan");
        @(negedge clk);
        bus0.start = 1'b1; bus0.max_row = 4'd3;
        @(negedge clk);
        bus0.start = 1'b0; bus0.pixel_valid = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", bus0.busy, 0);
        checkOutput("arst_row_ctr", bus0.row_ctr, 0);
        checkOutput("arst_win_x", bus0.win_x, 0);
        checkOutput("arst_win_y", bus0.win_y, 0);
        checkOutput("arst_window_valid", bus0.window_valid, 0);
        checkOutput("arst_col_enable", bus0.col_enable, 0);
        checkOutput("arst_col_reset", bus0.col_reset, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("norestart_busy", bus0.busy, 0);
            checkOutput("norestart_col_enable", bus0.col_enable, 0);
        end
        bus0.pixel_valid = 1'b0;
        applyStimulus(3, 100, -1);

        $display("[TB] single-pixel window and count saturation");
        @(negedge clk);
        bus1.start = 1'b1; bus1.max_row = 4'd15;
        @(negedge clk);
        bus1.start = 1'b0; bus1.pixel_valid = 1'b1;
        checkOutput("ws1_frame_start", bus1.frame_start, 1);
        n1 = 0; idx1 = 0; acc1 = 1'b0; fin1 = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin1; cyc++) begin
            @(negedge clk);
            checkOutput("ws1_window_valid", bus1.window_valid, acc1);
            if (acc1) begin
                checkOutput("ws1_win_x", bus1.win_x, idx1 % COLS1);
                checkOutput("ws1_win_y", bus1.win_y, idx1 / COLS1);
            end
            checkOutput("ws1_window_count", bus1.window_count, (n1 > 255) ? 255 : n1);
            if (acc1 && idx1 == COLS1 * 16 - 1) begin
                checkOutput("ws1_frame_done", bus1.frame_done, 1);
                bus1.pixel_valid = 1'b0;
                fin1 = 1'b1;
            end else begin
                acc1 = 1'b1;
                idx1 = n1;
                n1++;
            end
        end
        if (!fin1) checkOutput("ws1_timeout", 0, 1);
        @(negedge clk);
        checkOutput("ws1_saturated", bus1.window_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_scan_fsm.md
Name: window_scan_fsm

Overview:
Raster-scan controller that sits directly upstream and downstream of the column counter in the Haar detection front end. It gates the counter's enable with the pixel stream and consumes the counter's column index and end-of-line flag. From these it tracks the row index and flags every pixel position where a full WINDOW_SIZE x WINDOW_SIZE Haar window ends. It emits window origin coordinates, a running window count and frame-level start/done pulses to the classifier scheduler.

Parameters:
DATA_WIDTH, 8, width of column/row indices; must match the column counter width.
WINDOW_SIZE, 24, Haar window edge in pixels; legal range 1..2^DATA_WIDTH.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a frame scan; sampled in IDLE only
abort  input  1  synchronous abort of current scan; returns to IDLE
pixel_valid  input  1  one pixel presented this cycle
max_row  input  DATA_WIDTH  index of last image row; sampled on start
col_ctr  input  DATA_WIDTH  column index from column counter ctr_out
col_end  input  1  end_count from column counter (col_ctr == last column)
col_enable  output  1  drives column counter enable
col_reset  output  1  active-high one-cycle clear to column counter reset
busy  output  1  high in SCAN
row_ctr  output  DATA_WIDTH  current row index
window_valid  output  1  registered; window ending at accepted pixel is complete
win_x  output  DATA_WIDTH  window origin column, valid with window_valid
win_y  output  DATA_WIDTH  window origin row, valid with window_valid
window_count  output  2*DATA_WIDTH  windows flagged this frame, saturating
frame_start  output  1  one-cycle pulse on IDLE->SCAN
frame_done  output  1  one-cycle pulse on last pixel of frame

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, except col_reset=1 while reset is asserted.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 and abort=0: go to SCAN next cycle.
  - On that transition: frame_start=1 and col_reset=1 for exactly one cycle.
  - Also on that transition: latch max_row; clear row_ctr and window_count.
- col_enable = pixel_valid when state==SCAN and col_reset==0; otherwise 0 (combinational). pixel_valid is ignored outside SCAN.
- SCAN, accepted pixel (col_enable=1):
  - col_end=1 and row_ctr != max_row latched: row_ctr increments next cycle.
  - col_end=1 and row_ctr == max_row: go to DONE; frame_done=1 next cycle. row_ctr holds its value until the next start.
- Window test on each accepted pixel: col_ctr >= WINDOW_SIZE-1 and row_ctr >= WINDOW_SIZE-1.
  - If true, next cycle: window_valid=1, win_x = col_ctr-(WINDOW_SIZE-1), win_y = row_ctr-(WINDOW_SIZE-1), window_count+1.
  - Latency is exactly 1 cycle after acceptance; window_valid is 0 on all other cycles.
  - win_x/win_y hold their last value when window_valid=0.
- window_count saturates at all-ones and does not wrap.
- DONE: lasts one cycle, then IDLE unconditionally. start is ignored in DONE.
- abort=1 in SCAN or DONE:
  - Go to IDLE next cycle; col_reset=1 for one cycle; row_ctr cleared.
  - window_count holds; no frame_done.
  - Abort wins over a simultaneous last pixel or start.
- Column counter wraps to 0 by itself on col_end. This block never assumes col_ctr==0 after an abort without its own col_reset.
- max_row < WINDOW_SIZE-1: no windows flagged; frame still completes with frame_done.
- WINDOW_SIZE=1: every accepted pixel flags a window; win_x=col_ctr, win_y=row_ctr.
- Comparisons and subtractions are unsigned DATA_WIDTH. The subtraction only occurs when the window test passes, so it never underflows.

Test Plan:
- DATA_WIDTH=4, WINDOW_SIZE=3, counter max_size=3, max_row=3; start, then 16 continuous pixels -> frame_start at cycle 1. window_valid on 4 pixels at (col,row) in {2,3}x{2,3} with win (0,0),(1,0),(0,1),(1,1). window_count=4; frame_done 1 cycle after pixel 16; returns to IDLE.
- Same frame with pixel_valid toggling 1/0 -> col_enable mirrors pixel_valid only in SCAN. Identical window sequence and count; frame_done after the 16th accepted pixel.
- Abort asserted on the 7th pixel -> IDLE next cycle, col_reset pulse, row_ctr=0, no frame_done. A following start plus 16 pixels gives the full frame result.
- max_row=1, WINDOW_SIZE=3 -> zero window_valid pulses, window_count=0, frame_done after 8 pixels.
- reset driven low mid-SCAN -> all outputs 0 immediately (async), col_reset=1; after release, start required to scan again.
- start and abort both high in IDLE -> stays IDLE, no frame_start.
